processor: RTL and testbench

- Minimal 4-bit single-cycle processor core: two general registers (R0, R1), one 4-bit ALU, a small data memory.
- Executes one 4-bit opcode per clock from the `instruction` input; there is no program counter or fetch.
- Exposes the ALU result and both registers as debug outputs.
- Used as a teaching/bring-up core driven directly by a stimulus source.

---
 rtl/processor_pkg.sv | 25 ++
 rtl/processor_alu.sv | 34 +++
 rtl/processor.sv | 109 ++++++++++
 tb/tb_processor.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/processor_pkg.sv
// Shared definitions for the 4-bit teaching core: data width, opcodes, ALU select.
// Optional status flags are enabled with the PROC_FLAGS_EN macro.
package processor_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [3:0] {
    OP_NOP   = 4'b0000,
    OP_ADD   = 4'b0001,
    OP_SUB   = 4'b0010,
    OP_AND   = 4'b0011,
    OP_OR    = 4'b0100,
    OP_LOAD  = 4'b0101,
    OP_STORE = 4'b0110,
    OP_MOV   = 4'b0111
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_e;

endpackage

// File: rtl/processor_alu.sv
// Combinational 4-bit ALU; carry_o is the ADD carry-out or the SUB borrow (a < b).
module processor_alu
  import processor_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  alu_op_e           op_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum      = '0;
    result_o = '0;
    carry_o  = 1'b0;
    case (op_i)
      ALU_ADD: begin
        sum      = {1'b0, a_i} + {1'b0, b_i};
        result_o = sum[DATA_W-1:0];
        carry_o  = sum[DATA_W];
      end
      ALU_SUB: begin
        result_o = a_i - b_i;
        carry_o  = (a_i < b_i);
      end
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/processor.sv
// Single-cycle 4-bit core: R0/R1, registered ALU result and a small data memory.
// Defining PROC_FLAGS_EN adds registered zero_flag and carry_flag outputs.
module processor
  import processor_pkg::*;
#(
  parameter logic [DATA_W-1:0] R0_INIT   = 4'd6,
  parameter logic [DATA_W-1:0] R1_INIT   = 4'd3,
  parameter int                MEM_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        instruction,
  output logic [DATA_W-1:0] alu_result_debug,
  output logic [DATA_W-1:0] reg0_debug,
  output logic [DATA_W-1:0] reg1_debug
`ifdef PROC_FLAGS_EN
  ,
  output logic              zero_flag,
  output logic              carry_flag
`endif
);

  logic [DATA_W-1:0] r0_q, r0_d;
  logic [DATA_W-1:0] r1_q;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] mem0_d;

  alu_op_e           alu_op;
  logic              is_alu;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;

  processor_alu u_alu (
    .a_i      (r0_q),
    .b_i      (r1_q),
    .op_i     (alu_op),
    .result_o (alu_res),
    .carry_o  (alu_carry)
  );

  // Decode; reserved opcodes fall into the default arm and change nothing.
  always_comb begin
    r0_d   = r0_q;
    alu_d  = alu_q;
    mem0_d = mem_q[0];
    alu_op = ALU_ADD;
    is_alu = 1'b0;
    case (instruction)
      OP_ADD:   begin alu_op = ALU_ADD; is_alu = 1'b1; end
      OP_SUB:   begin alu_op = ALU_SUB; is_alu = 1'b1; end
      OP_AND:   begin alu_op = ALU_AND; is_alu = 1'b1; end
      OP_OR:    begin alu_op = ALU_OR;  is_alu = 1'b1; end
      OP_LOAD:  r0_d   = mem_q[0];
      OP_STORE: mem0_d = r0_q;
      OP_MOV:   r0_d   = r1_q;
      default:  ;
    endcase
    if (is_alu) alu_d = alu_res;
  end

`ifdef PROC_FLAGS_EN
  logic zero_q, zero_d;
  logic carry_q, carry_d;

  always_comb begin
    zero_d  = zero_q;
    carry_d = carry_q;
    if (is_alu) begin
      zero_d  = (alu_res == '0);
      carry_d = (alu_op == ALU_ADD || alu_op == ALU_SUB) ? alu_carry : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign zero_flag  = zero_q;
  assign carry_flag = carry_q;
`else
  logic unused_carry;
  assign unused_carry = alu_carry;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r0_q  <= R0_INIT;
      r1_q  <= R1_INIT;
      alu_q <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      r0_q     <= r0_d;
      alu_q    <= alu_d;
      mem_q[0] <= mem0_d;
    end
  end

  assign alu_result_debug = alu_q;
  assign reg0_debug       = r0_q;
  assign reg1_debug       = r1_q;

endmodule

// File: tb/tb_processor.sv
// Bench for processor: three parameterisations driven in lockstep against an arithmetic model.
module tb_processor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] instruction;
  logic [3:0] alu_o [3];
  logic [3:0] r0_o  [3];
  logic [3:0] r1_o  [3];
`ifdef PROC_FLAGS_EN
  logic       zf [3];
  logic       cf [3];
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [11:0] exp_q[$];

  // Reference state per instance.
  int m_r0 [3], m_r1 [3], m_alu [3], m_mem [3], m_z [3], m_c [3];
  int init0 [3] = '{6, 2, 9};
  int init1 [3] = '{3, 5, 9};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  processor dut_a (
    .clk(clk), .rst_n(rst_n), .instruction(instruction),
    .alu_result_debug(alu_o[0]), .reg0_debug(r0_o[0]), .reg1_debug(r1_o[0])
`ifdef PROC_FLAGS_EN
    , .zero_flag(zf[0]), .carry_flag(cf[0])
`endif
  );

  processor #(.R0_INIT(4'd2), .R1_INIT(4'd5)) dut_b (
    .clk(clk), .rst_n(rst_n), .instruction(instruction),
    .alu_result_debug(alu_o[1]), .reg0_debug(r0_o[1]), .reg1_debug(r1_o[1])
`ifdef PROC_FLAGS_EN
    , .zero_flag(zf[1]), .carry_flag(cf[1])
`endif
  );

  processor #(.R0_INIT(4'd9), .R1_INIT(4'd9)) dut_c (
    .clk(clk), .rst_n(rst_n), .instruction(instruction),
    .alu_result_debug(alu_o[2]), .reg0_debug(r0_o[2]), .reg1_debug(r1_o[2])
`ifdef PROC_FLAGS_EN
    , .zero_flag(zf[2]), .carry_flag(cf[2])
`endif
  );

  // ---------------- reference model ----------------
  task automatic model_step(input bit rst, input int op);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_r0[i] = init0[i]; m_r1[i] = init1[i];
        m_alu[i] = 0; m_mem[i] = 0; m_z[i] = 0; m_c[i] = 0;
      end else begin
        case (op)
          1: begin
            m_alu[i] = (m_r0[i] + m_r1[i]) % 16;
            m_c[i] = (m_r0[i] + m_r1[i] > 15) ? 1 : 0;
            m_z[i] = (m_alu[i] == 0) ? 1 : 0;
          end
          2: begin
            m_alu[i] = (m_r0[i] - m_r1[i] + 16) % 16;
            m_c[i] = (m_r0[i] < m_r1[i]) ? 1 : 0;
            m_z[i] = (m_alu[i] == 0) ? 1 : 0;
          end
          3: begin
            m_alu[i] = m_r0[i] & m_r1[i];
            m_c[i] = 0; m_z[i] = (m_alu[i] == 0) ? 1 : 0;
          end
          4: begin
            m_alu[i] = m_r0[i] | m_r1[i];
            m_c[i] = 0; m_z[i] = (m_alu[i] == 0) ? 1 : 0;
          end
          5: m_r0[i] = m_mem[i];
          6: m_mem[i] = m_r0[i];
          7: m_r0[i] = m_r1[i];
          default: ;
        endcase
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [11:0] e;
    for (int i = 0; i < 3; i++)
      exp_q.push_back({m_alu[i][3:0], m_r0[i][3:0], m_r1[i][3:0]});
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      chk($sformatf("%s[%0d]", tag, i), {alu_o[i], r0_o[i], r1_o[i]}, e);
`ifdef PROC_FLAGS_EN
      chk($sformatf("%s_flags[%0d]", tag, i), {10'b0, zf[i], cf[i]},
          {10'b0, m_z[i] != 0, m_c[i] != 0});
`endif
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit rst, input logic [3:0] op, input string tag);
    rst_n = ~rst;
    instruction = op;
    @(posedge clk);
    #1;
    model_step(rst, int'(op));
    check_state(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    instruction = 4'h0;

    step(1'b1, 4'h1, "reset");
    step(1'b0, 4'h1, "add");
    chk("a_add_lit", {alu_o[0], r0_o[0], r1_o[0]}, 12'h963);
    chk("b_add_lit", {8'h0, alu_o[1]}, 12'h007);
    chk("c_add_lit", {8'h0, alu_o[2]}, 12'h002);
`ifdef PROC_FLAGS_EN
    chk("c_add_flags_lit", {10'b0, zf[2], cf[2]}, 12'h001);
`endif
    step(1'b0, 4'h2, "sub");
    chk("a_sub_lit", {8'h0, alu_o[0]}, 12'h003);
    chk("b_sub_wrap_lit", {8'h0, alu_o[1]}, 12'h00d);
`ifdef PROC_FLAGS_EN
    chk("c_sub_flags_lit", {6'b0, alu_o[2], zf[2], cf[2]}, 12'h002);
`endif
    step(1'b0, 4'h3, "and");
    chk("a_and_lit", {8'h0, alu_o[0]}, 12'h002);
    step(1'b0, 4'h4, "or");
    chk("a_or_lit", {alu_o[0], r0_o[0], r1_o[0]}, 12'h763);

    // Memory must come out of reset cleared.
    step(1'b1, 4'h0, "reset2");
    step(1'b0, 4'h5, "load_cleared");
    chk("a_load_cleared_lit", {8'h0, r0_o[0]}, 12'h000);

    step(1'b1, 4'h0, "reset3");
    step(1'b0, 4'h6, "store");
    step(1'b0, 4'h5, "load_back");
    chk("a_load_back_lit", {8'h0, r0_o[0]}, 12'h006);
    step(1'b0, 4'h7, "mov");
    chk("a_mov_lit", {4'h0, r0_o[0], r1_o[0]}, 12'h033);
    step(1'b0, 4'h0, "nop");
    step(1'b0, 4'ha, "reserved");

    // Outputs must not follow the instruction input between edges.
    instruction = 4'h1;
    #2;
    check_state("no_comb_path");

    step(1'b0, 4'h1, "add_pre_rst");
    step(1'b1, 4'h1, "rst_with_add");
    chk("a_rst_discard_lit", {alu_o[0], r0_o[0], r1_o[0]}, 12'h063);

    repeat (300) begin
      step($urandom_range(0, 19) == 0, 4'($urandom_range(0, 15)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
